// File: rtl/hamming_pkg.sv
// hamming_pkg: shared definitions for the SECDED (16,11) decode engine.
//   - codeword layout: bit k of the codeword is Hamming position k,
//     bit 0 is the overall parity p0, bits 1/2/4/8 are p1/p2/p4/p8.
//   - syndrome masks: syndrome bit n is the XOR of every position whose
//     index has bit n set.
//   - FSM state encodings (dec_state_t) and the error classification flag_t.
//   - extract_data(): pulls d11..d1 out of a 16-bit codeword.
package hamming_pkg;

  // Data bit positions inside the codeword
  localparam int D1_POS    = 3;
  localparam int D4_2_LO   = 5;
  localparam int D4_2_HI   = 7;
  localparam int D11_5_LO  = 9;
  localparam int D11_5_HI  = 15;

  // Positions contributing to each syndrome bit (position 0 excluded)
  localparam logic [15:0] SYN0_MASK = 16'hAAAA;
  localparam logic [15:0] SYN1_MASK = 16'hCCCC;
  localparam logic [15:0] SYN2_MASK = 16'hF0F0;
  localparam logic [15:0] SYN3_MASK = 16'hFF00;

  typedef logic [2:0] dec_state_t;
  localparam dec_state_t ST_IDLE   = 3'd0;
  localparam dec_state_t ST_RD_LO  = 3'd1;
  localparam dec_state_t ST_RD_HI  = 3'd2;
  localparam dec_state_t ST_DECODE = 3'd3;
  localparam dec_state_t ST_WR_LO  = 3'd4;
  localparam dec_state_t ST_WR_HI  = 3'd5;
  localparam dec_state_t ST_FIN    = 3'd6;

  typedef enum logic [1:0] {
    CLEAN  = 2'b00,
    SINGLE = 2'b01,
    DOUBLE = 2'b10
  } flag_t;

  // Returns {d11..d1}; d1 lands in bit 0.
  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[D11_5_HI:D11_5_LO], cw[D4_2_HI:D4_2_LO], cw[D1_POS]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational SECDED (16,11) checker/corrector.
// Ports:
//   i_cw      in  16  codeword as read from memory
//   o_flag    out 2   CLEAN / SINGLE / DOUBLE classification
//   o_cw_corr out 16  codeword with the single-error position flipped
//                     (unchanged for CLEAN and DOUBLE)
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [15:0] i_cw,
  output flag_t       o_flag,
  output logic [15:0] o_cw_corr
);

  logic [3:0] w_syn;
  logic       w_q;

  // Syndrome, overall parity, classification and correction
  always_comb begin
    w_syn     = {^(i_cw & SYN3_MASK), ^(i_cw & SYN2_MASK),
                 ^(i_cw & SYN1_MASK), ^(i_cw & SYN0_MASK)};
    w_q       = ^i_cw;
    o_cw_corr = i_cw;
    if (w_q) begin
      // Odd overall parity: one bit flipped; syndrome 0 points at p0 (bit 0).
      o_flag            = SINGLE;
      o_cw_corr[w_syn]  = ~i_cw[w_syn];
    end else if (w_syn != 4'd0) begin
      o_flag = DOUBLE;
    end else begin
      o_flag = CLEAN;
    end
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: memory-master engine that decodes NUM_MSG SECDED
// (16,11) codewords from SRC_BASE and writes {d8..d1} and
// {F1,F0,3'b000,d11..d9} byte pairs to DST_BASE.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               1-cycle pulse, accepted in IDLE or FIN
//   done                high from end of run until next accepted start
//   busy                high while a run is in progress
//   mem_addr [AW]       byte address (registered)
//   mem_wr_en           byte write strobe, only in WR_LO / WR_HI
//   mem_wr_data [8]     write byte
//   mem_rd_data [8]     combinational read data for mem_addr
// Optional feature (macro HAMMING_DEC_STATS_EN):
//   n_single / n_double [4] saturating per-run error counters.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [3:0]    n_single,
  output logic [3:0]    n_double
`endif
);

  localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_MSG - 1);
  localparam logic [AW-1:0] SRC_A     = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A     = AW'(DST_BASE);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);

  dec_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [15:0]   r_cw, w_cw_corr;
  flag_t         w_flag;
  logic [10:0]   w_data;
  logic [7:0]    r_hi;
  logic          w_start_ok;
  logic [AW-1:0] w_off, w_addr_nxt;
  logic          w_wr_en_nxt;
  logic [7:0]    w_wr_data_nxt;
  logic          r_done, r_busy, r_mem_wr_en;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wr_data;

  hamming_syndrome u_syndrome (
    .i_cw      (r_cw),
    .o_flag    (w_flag),
    .o_cw_corr (w_cw_corr)
  );

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
  assign w_data     = extract_data(w_cw_corr);
  // Offset in AW bits so address arithmetic wraps modulo 2^AW.
  assign w_off      = AW'({w_idx_nxt, 1'b0});

  // Next-state and message index
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          w_state_nxt = ST_RD_LO;
          w_idx_nxt   = IDX_ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RD_LO:  w_state_nxt = ST_RD_HI;
      ST_RD_HI:  w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = ST_WR_LO;
      ST_WR_LO:  w_state_nxt = ST_WR_HI;
      ST_WR_HI: begin
        if (r_idx == IDX_LAST) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_RD_LO;
          w_idx_nxt   = r_idx + IDX_ONE;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory-port values for the state being entered, so the registered
  // address is already valid during the read cycles.
  always_comb begin
    w_addr_nxt    = ADDR_ZERO;
    w_wr_en_nxt   = 1'b0;
    w_wr_data_nxt = 8'h00;
    case (w_state_nxt)
      ST_RD_LO: w_addr_nxt = SRC_A + w_off;
      ST_RD_HI: w_addr_nxt = SRC_A + w_off + ADDR_ONE;
      ST_WR_LO: begin
        w_addr_nxt    = DST_A + w_off;
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = w_data[7:0];
      end
      ST_WR_HI: begin
        w_addr_nxt    = DST_A + w_off + ADDR_ONE;
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = r_hi;
      end
      default: begin
        w_addr_nxt    = ADDR_ZERO;
        w_wr_en_nxt   = 1'b0;
      end
    endcase
  end

  // FSM, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= IDX_ZERO;
      r_cw          <= 16'h0000;
      r_hi          <= 8'h00;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_addr    <= ADDR_ZERO;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_mem_addr    <= w_addr_nxt;
      r_mem_wr_en   <= w_wr_en_nxt;
      r_mem_wr_data <= w_wr_data_nxt;
      if (r_state == ST_RD_LO) begin
        r_cw[7:0] <= mem_rd_data;
      end else if (r_state == ST_RD_HI) begin
        r_cw[15:8] <= mem_rd_data;
      end else begin
        r_cw <= r_cw;
      end
      if (r_state == ST_DECODE) begin
        r_hi <= {w_flag, 3'b000, w_data[10:8]};
      end else begin
        r_hi <= r_hi;
      end
      if (w_start_ok) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (r_state == ST_FIN) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_busy <= r_busy;
        r_done <= r_done;
      end
    end
  end

  assign done        = r_done;
  assign busy        = r_busy;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_data = r_mem_wr_data;

`ifdef HAMMING_DEC_STATS_EN
  logic [3:0] r_n_single, r_n_double;

  // Per-run saturating error counters, cleared by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_single <= 4'h0;
      r_n_double <= 4'h0;
    end else if (w_start_ok) begin
      r_n_single <= 4'h0;
      r_n_double <= 4'h0;
    end else if (r_state == ST_DECODE) begin
      case (w_flag)
        SINGLE:  r_n_single <= (r_n_single == 4'hF) ? r_n_single : r_n_single + 4'h1;
        DOUBLE:  r_n_double <= (r_n_double == 4'hF) ? r_n_double : r_n_double + 4'h1;
        default: r_n_single <= r_n_single;
      endcase
    end else begin
      r_n_single <= r_n_single;
      r_n_double <= r_n_double;
    end
  end

  assign n_single = r_n_single;
  assign n_double = r_n_double;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: expected writes are queued when a
// run is launched; a negedge monitor pops and compares every DUT write.
module tb_hamming_dec_engine;

  localparam int NUM_MSG = 15;
  localparam int SRC     = 30;
  localparam int DST     = 0;
  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic       clk = 1'b0;
  logic       reset, start;
  logic       done, busy, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
`ifdef HAMMING_DEC_STATS_EN
  logic [3:0] n_single, n_double;
`endif

  logic [7:0]  mem [0:255];
  logic [15:0] cw_tab [NUM_MSG];
  logic [7:0]  lo_tab [NUM_MSG];
  logic [7:0]  hi_tab [NUM_MSG];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];

  hamming_dec_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .n_single    (n_single),
    .n_double    (n_double)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] msg);
    logic [15:0] cw;
    logic        b;
    cw = 16'h0000;
    for (int j = 0; j < 11; j++) cw[DPOS[j]] = msg[j];
    for (int p = 1; p < 16; p = p * 2) begin
      b = 1'b0;
      for (int k = 1; k < 16; k++)
        if (((k & p) != 0) && (k != p)) b = b ^ cw[k];
      cw[p] = b;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    for (int j = 0; j < 11; j++) d[j] = cw[DPOS[j]];
    return d;
  endfunction

  // Fill table slot i: nflip 0 clean, 1 single (corrected), 2 double (raw data)
  task automatic set_entry(input int i, input logic [10:0] msg, input logic [15:0] mask);
    logic [15:0] cw;
    logic [10:0] d;
    logic [1:0]  f;
    int          n;
    cw = encode(msg) ^ mask;
    n  = $countones(mask);
    d  = (n == 2) ? extract(cw) : msg;
    f  = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b10);
    cw_tab[i] = cw;
    lo_tab[i] = d[7:0];
    hi_tab[i] = {f, 3'b000, d[10:8]};
  endtask

  task automatic load_and_queue();
    for (int i = 0; i < NUM_MSG; i++) begin
      mem[SRC + 2*i]     = cw_tab[i][7:0];
      mem[SRC + 2*i + 1] = cw_tab[i][15:8];
      exp_q.push_back({8'(DST + 2*i), lo_tab[i]});
      exp_q.push_back({8'(DST + 2*i + 1), hi_tab[i]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full run; poke>0 pulses start while busy at that cycle count
  task automatic do_run(input int poke, input string tag);
    int cyc;
    bit seen;
    load_and_queue();
    pulse_start();
    check({tag, "_busy_at_start"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == poke) ? 1'b1 : 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, cyc, 32'd76);
    check({tag, "_busy_after_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, mon_e[15:8]});
        check("wr_data", {24'd0, mem_wr_data}, {24'd0, mon_e[7:0]});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Run A: all 0xFFFF
    for (int i = 0; i < NUM_MSG; i++) begin
      cw_tab[i] = 16'hFFFF;
      lo_tab[i] = 8'hFF;
      hi_tab[i] = 8'h07;
    end
    do_run(0, "allones");
`ifdef HAMMING_DEC_STATS_EN
    check("allones_n_single", {28'd0, n_single}, 32'd0);
    check("allones_n_double", {28'd0, n_double}, 32'd0);
`endif

    // Run B: 5 single, 3 double, 7 clean; start poked mid-run
    cw_tab[0] = 16'h0020; lo_tab[0] = 8'h00; hi_tab[0] = 8'h40;
    cw_tab[1] = 16'hFFFE; lo_tab[1] = 8'hFF; hi_tab[1] = 8'h47;
    cw_tab[2] = 16'h0003; lo_tab[2] = 8'h00; hi_tab[2] = 8'h80;
    set_entry(3,  11'h5A5, 16'h0000);
    set_entry(4,  11'h123, 16'h0001);
    set_entry(5,  11'h0F0, 16'h8000);
    set_entry(6,  11'h3C3, 16'h0100);
    set_entry(7,  11'h001, 16'h0000);
    set_entry(8,  11'h400, 16'h0000);
    set_entry(9,  11'h2AA, 16'h0300);
    set_entry(10, 11'h555, 16'h8001);
    set_entry(11, 11'h7FE, 16'h0000);
    set_entry(12, 11'h000, 16'h0000);
    set_entry(13, 11'h6B9, 16'h0000);
    set_entry(14, 11'h1F4, 16'h0000);
    do_run(20, "mixed");
`ifdef HAMMING_DEC_STATS_EN
    check("mixed_n_single", {28'd0, n_single}, 32'd5);
    check("mixed_n_double", {28'd0, n_double}, 32'd3);
`endif

    // Run C: reset during WR_LO of message 7, then a full rerun
    for (int i = 0; i < NUM_MSG; i++) set_entry(i, 11'(i * 163 + 5), 16'h0000);
    load_and_queue();
    pulse_start();
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_wr_en && (mem_addr == 8'(DST + 14))) found = 1'b1;
    end
    check("reach_msg7_wr_lo", {31'd0, found}, 32'd1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("midrst_addr", {24'd0, mem_addr}, 32'd0);
`ifdef HAMMING_DEC_STATS_EN
    check("midrst_n_single", {28'd0, n_single}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    check("post_rst_idle_done", {31'd0, done}, 32'd0);
    do_run(0, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
